// File: rtl/gf16_red_pkg.sv
// Shared definitions for the GF(2^M) sequential reduction stage:
// FSM state encoding, default field degree / polynomial and product width.
package gf16_red_pkg;

   localparam int              GF_M    = 4;
   localparam logic [GF_M-1:0] GF_POLY = 4'b0011;   // x^4 + x + 1, x^4 implicit
   localparam int              GF_W    = 2*GF_M - 1; // carry-less product width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RED  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/gf16_red_step.sv
// One step of bit-serial polynomial reduction: if bit cnt of r is set,
// cancel it by XOR-ing in the modulus aligned so its x^M term lands on cnt.
// Only meaningful for cnt >= M; the caller ignores the result otherwise.
module gf16_red_step
   import gf16_red_pkg::*;
#(
   parameter int M = GF_M
) (
   input  logic [2*M-2:0]               r,
   input  logic [$clog2(2*M-1)-1:0]     cnt,
   input  logic [M-1:0]                 poly,
   output logic [2*M-2:0]               r_next
);

   localparam int W  = 2*M - 1;
   localparam int CW = $clog2(W);

   logic [W-1:0]  poly_full;
   logic [W-1:0]  shifted;
   logic [CW-1:0] shamt;

   // Conditionally subtract (XOR) the aligned modulus from the work value
   always_comb begin
      poly_full = W'({1'b1, poly});
      shamt     = cnt - CW'(M);
      shifted   = poly_full << shamt;
      r_next    = r[cnt] ? (r ^ shifted) : r;
   end

endmodule

// File: rtl/gf16_reduce_seq.sv
// Sequential GF(2^M) reduction stage. Accepts a (2M-1)-bit carry-less product
// on a valid/ready input, reduces it one bit per cycle from the top bit down
// to bit M (M-1 RED cycles regardless of data), then holds the M-bit result
// on a valid/ready output until it is taken.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid and payload stay stable until that edge. in_ready is high
// only in IDLE, so a product is never taken in the same cycle as a result.
//
// Optional build macro GF16_RED_ACC_EN: adds an M-bit accumulator and the
// acc_clr input; each delivered result is acc ^ reduced value and becomes the
// new acc. acc_clr wins over a simultaneous result handshake.
//
// All outputs come straight from flops; nothing combinational from inputs.
module gf16_reduce_seq
   import gf16_red_pkg::*;
#(
   parameter int           M    = GF_M,
   parameter logic [M-1:0] POLY = GF_POLY
) (
   input  logic             clk,
   input  logic             rst,
`ifdef GF16_RED_ACC_EN
   input  logic             acc_clr,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*M-2:0]   prod,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [M-1:0]     res,
   output logic             busy
);

   localparam int W  = 2*M - 1;
   localparam int CW = $clog2(W);

   state_t        state_q, state_d;
   logic [W-1:0]  r_q, r_d, r_step;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          busy_q, busy_d;
   logic [M-1:0]  res_q, res_d;
`ifdef GF16_RED_ACC_EN
   logic [M-1:0]  acc_q, acc_d;
`endif

   gf16_red_step #(.M(M)) u_step (
      .r      (r_q),
      .cnt    (cnt_q),
      .poly   (POLY),
      .r_next (r_step)
   );

   // Next-state, work register and bit counter
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               r_d     = prod;
               cnt_d   = CW'(W - 1);
               state_d = RED;
            end
         end
         RED: begin
            r_d = r_step;
            if (cnt_q == CW'(M)) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef GF16_RED_ACC_EN
   // Accumulator: clear has priority; otherwise capture the delivered result
   always_comb begin
      acc_d = acc_q;
      if (acc_clr) begin
         acc_d = '0;
      end else if (state_q == DONE && out_ready) begin
         acc_d = res_q;
      end
   end
`endif

   // Registered outputs, decoded from the next state so they align with it
   always_comb begin
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
      res_d       = '0;
      if (state_d == DONE) begin
`ifdef GF16_RED_ACC_EN
         res_d = acc_d ^ r_d[M-1:0];
`else
         res_d = r_d[M-1:0];
`endif
      end
   end

   // State and output flops; reset discards any in-flight product
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         r_q         <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         res_q       <= '0;
`ifdef GF16_RED_ACC_EN
         acc_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         res_q       <= res_d;
`ifdef GF16_RED_ACC_EN
         acc_q       <= acc_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign res       = res_q;

endmodule
